// File: rtl/cp0_pkg.sv
// CP0 register numbers, SR/Cause field positions and SR packing helper.
package cp0_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    // SR fields
    localparam int SR_IM_LO = 10;
    localparam int SR_IM_HI = 15;
    localparam int SR_EXL   = 1;
    localparam int SR_IE    = 0;

    // Cause fields
    localparam int CAUSE_IP_LO = 10;
    localparam int CAUSE_IP_HI = 15;

    localparam int NUM_INT = SR_IM_HI - SR_IM_LO + 1;

    // Architecturally visible SR state
    typedef struct packed {
        logic [NUM_INT-1:0] im;
        logic               exl;
        logic               ie;
    } sr_t;

    // Place the SR fields at their register bit positions; other bits read 0.
    function automatic logic [31:0] sr_pack(input sr_t s);
        logic [31:0] r;
        r = '0;
        r[SR_IM_HI:SR_IM_LO] = s.im;
        r[SR_EXL]            = s.exl;
        r[SR_IE]             = s.ie;
        return r;
    endfunction

    // Place the pending lines at the Cause IP position; ExcCode stays 0.
    function automatic logic [31:0] cause_pack(input logic [NUM_INT-1:0] ip);
        logic [31:0] r;
        r = '0;
        r[CAUSE_IP_HI:CAUSE_IP_LO] = ip;
        return r;
    endfunction

endpackage

// File: rtl/cp0_sync.sv
// Multi-flop synchroniser for asynchronous level inputs, reset to 0.
module cp0_sync #(
    parameter int W      = 6,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [STAGES-1:0][W-1:0] chain;

    // Shift the raw lines through STAGES flops; the last stage is the safe copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/cp0_regs.sv
// CP0 register file (SR, Cause, EPC, PRId) and interrupt-request generator.
module cp0_regs
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID        = 32'h0000_4350,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  a,
    input  logic [31:0] din,
    input  logic        we,
    input  logic [31:0] pc,
    input  logic        exl_set,
    input  logic        exl_clr,
    input  logic [5:0]  hwint,
    output logic        int_req,
    output logic [31:0] epc,
    output logic [31:0] dout
);

    sr_t                sr_q;
    logic [31:0]        epc_q;
    logic [NUM_INT-1:0] ip;
    logic               sr_wr;
    logic               epc_wr;

    cp0_sync #(
        .W      (NUM_INT),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (hwint),
        .q     (ip)
    );

    assign sr_wr  = we && (a == CP0_SR);
    assign epc_wr = we && (a == CP0_EPC);

    // SR: IM/IE follow mtc0; EXL is set by entry, cleared by eret, else mtc0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            if (sr_wr) begin
                sr_q.im <= din[SR_IM_HI:SR_IM_LO];
                sr_q.ie <= din[SR_IE];
            end
            if (exl_set)      sr_q.exl <= 1'b1;
            else if (exl_clr) sr_q.exl <= 1'b0;
            else if (sr_wr)   sr_q.exl <= din[SR_EXL];
        end
    end

    // EPC: interrupt entry captures the PC and overrides a same-cycle mtc0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       epc_q <= '0;
        else if (exl_set) epc_q <= pc;
        else if (epc_wr)  epc_q <= din;
    end

    // Request is built from flops only, so it is glitch-free toward the FSM.
    assign int_req = sr_q.ie & ~sr_q.exl & (|(ip & sr_q.im));
    assign epc     = epc_q;

    // mfc0 read mux; unmapped numbers read 0.
    always_comb begin
        dout = '0;
        case (a)
            CP0_SR:    dout = sr_pack(sr_q);
            CP0_CAUSE: dout = cause_pack(ip);
            CP0_EPC:   dout = epc_q;
            CP0_PRID:  dout = PRID;
            default:   dout = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_regs.sv
// Directed vector table plus randomized run against a behavioural CP0 model.
module tb_cp0_regs;

    localparam logic [31:0] PRID = 32'h0000_4350;
    localparam int          SYNC = 2;
    localparam logic [31:0] SR_BITS = 32'h0000_FC03;

    logic        clk;
    logic        rst_n;
    logic [4:0]  a;
    logic [31:0] din;
    logic        we;
    logic [31:0] pc;
    logic        exl_set;
    logic        exl_clr;
    logic [5:0]  hwint;
    logic        int_req;
    logic [31:0] epc;
    logic [31:0] dout;

    int checks = 0;
    int errors = 0;

    cp0_regs #(.PRID(PRID), .SYNC_STAGES(SYNC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .din     (din),
        .we      (we),
        .pc      (pc),
        .exl_set (exl_set),
        .exl_clr (exl_clr),
        .hwint   (hwint),
        .int_req (int_req),
        .epc     (epc),
        .dout    (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: SR as a whole 32-bit register, EPC, and the hwint
    // samples taken at the most recent edges (IP = the one SYNC edges old).
    logic [31:0] m_sr;
    logic [31:0] m_epc;
    logic [5:0]  m_hist [SYNC];

    function automatic logic [5:0] m_ip();
        return m_hist[SYNC-1];
    endfunction

    function automatic logic m_int();
        return m_sr[0] && !m_sr[1] && ((m_ip() & m_sr[15:10]) != 6'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] ra);
        case (ra)
            5'd12:   return m_sr;
            5'd13:   return {16'd0, m_ip(), 10'd0};
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        m_sr  = 0;
        m_epc = 0;
        for (int i = 0; i < SYNC; i++) m_hist[i] = 6'd0;
    endtask

    // Apply one rising edge to the model using the currently driven inputs.
    task automatic m_edge();
        logic [31:0] nsr;
        nsr = m_sr;
        if (we && a == 5'd12) nsr = din & SR_BITS;
        if (exl_set)      nsr[1] = 1'b1;
        else if (exl_clr) nsr[1] = 1'b0;
        m_sr = nsr;
        if (exl_set)                m_epc = pc;
        else if (we && a == 5'd14)  m_epc = din;
        for (int i = SYNC-1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = hwint;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " int_req"}, {31'd0, int_req}, {31'd0, m_int()});
        chk({tag, " epc"},     epc,  m_epc);
        chk({tag, " dout"},    dout, m_read(a));
    endtask

    // One clock: edge, model update, sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic drive(input logic w, input logic [4:0] ra, input logic [31:0] d,
                         input logic es, input logic ec, input logic [31:0] p,
                         input logic [5:0] h);
        we = w; a = ra; din = d; exl_set = es; exl_clr = ec; pc = p; hwint = h;
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  a;
        logic [31:0] din;
        logic        es;
        logic        ec;
        logic [31:0] pc;
        logic [5:0]  hw;
        logic        x_int;
        logic [31:0] x_epc;
        logic [31:0] x_dout;
    } vec_t;

    vec_t vt [18];

    initial begin
        // Directed sequence: enable path, entry/return, collision, masking,
        // read-only registers, then hwint deassert latency.
        vt[0]  = '{1, 12, 32'h0000_0401, 0, 0, 0,            6'd0, 0, 32'h0,         32'h0000_0401};
        vt[1]  = '{0, 13, 32'h0,         0, 0, 0,            6'd1, 0, 32'h0,         32'h0000_0000};
        vt[2]  = '{0, 13, 32'h0,         0, 0, 0,            6'd1, 1, 32'h0,         32'h0000_0400};
        vt[3]  = '{0, 14, 32'h0,         1, 0, 32'h0000_3010, 6'd1, 0, 32'h0000_3010, 32'h0000_3010};
        vt[4]  = '{0, 12, 32'h0,         0, 0, 0,            6'd1, 0, 32'h0000_3010, 32'h0000_0403};
        vt[5]  = '{0, 12, 32'h0,         0, 1, 0,            6'd1, 1, 32'h0000_3010, 32'h0000_0401};
        vt[6]  = '{0, 12, 32'h0,         0, 1, 0,            6'd1, 1, 32'h0000_3010, 32'h0000_0401};
        vt[7]  = '{0, 12, 32'h0,         0, 1, 0,            6'd1, 1, 32'h0000_3010, 32'h0000_0401};
        vt[8]  = '{1, 14, 32'hDEAD_BEEF, 1, 0, 32'h0000_3000, 6'd1, 0, 32'h0000_3000, 32'h0000_3000};
        vt[9]  = '{0, 14, 32'h0,         0, 1, 0,            6'd1, 1, 32'h0000_3000, 32'h0000_3000};
        vt[10] = '{1, 12, 32'h0000_0801, 0, 0, 0,            6'd1, 0, 32'h0000_3000, 32'h0000_0801};
        vt[11] = '{1, 12, 32'h0000_0400, 0, 0, 0,            6'd1, 0, 32'h0000_3000, 32'h0000_0400};
        vt[12] = '{1, 13, 32'hFFFF_FFFF, 0, 0, 0,            6'd1, 0, 32'h0000_3000, 32'h0000_0400};
        vt[13] = '{1, 15, 32'hFFFF_FFFF, 0, 0, 0,            6'd1, 0, 32'h0000_3000, 32'h0000_4350};
        vt[14] = '{1, 3,  32'hFFFF_FFFF, 0, 0, 0,            6'd1, 0, 32'h0000_3000, 32'h0000_0000};
        vt[15] = '{1, 12, 32'hFFFF_FFFF, 0, 0, 0,            6'd1, 0, 32'h0000_3000, 32'h0000_FC03};
        vt[16] = '{0, 12, 32'h0,         0, 1, 0,            6'd0, 1, 32'h0000_3000, 32'h0000_FC01};
        vt[17] = '{0, 13, 32'h0,         0, 0, 0,            6'd0, 0, 32'h0000_3000, 32'h0000_0000};

        m_reset();
        rst_n = 1'b0;
        drive(0, 15, 0, 0, 0, 0, 6'd0);
        #1;
        chk("rst int_req", {31'd0, int_req}, 32'd0);
        chk("rst epc", epc, 32'd0);
        chk("rst dout prid", dout, 32'h0000_4350);
        a = 5'd12;
        #1;
        chk("rst dout sr", dout, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            drive(vt[i].we, vt[i].a, vt[i].din, vt[i].es, vt[i].ec, vt[i].pc, vt[i].hw);
            step();
            chk($sformatf("vec%0d int_req", i), {31'd0, int_req}, {31'd0, vt[i].x_int});
            chk($sformatf("vec%0d epc", i), epc, vt[i].x_epc);
            chk($sformatf("vec%0d dout", i), dout, vt[i].x_dout);
            chk_model($sformatf("vec%0d model", i));
        end

        // Rebuild a pending request, then reset asynchronously between edges.
        drive(1, 12, 32'h0000_FC01, 0, 0, 0, 6'h3F); step();
        drive(1, 14, 32'h1234_5678, 0, 0, 0, 6'h3F); step();
        drive(0, 12, 0, 0, 0, 0, 6'h3F); step();
        chk("pre-reset int_req", {31'd0, int_req}, 32'd1);
        #2 rst_n = 1'b0;
        m_reset();
        #1;
        chk("mid rst int_req", {31'd0, int_req}, 32'd0);
        chk("mid rst epc", epc, 32'd0);
        chk("mid rst dout sr", dout, 32'd0);
        a = 5'd15;
        #1;
        chk("mid rst dout prid", dout, 32'h0000_4350);
        hwint = 6'd0;
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] ra;
            case ($urandom_range(0, 5))
                0: ra = 5'd12;
                1: ra = 5'd13;
                2: ra = 5'd14;
                3: ra = 5'd15;
                4: ra = 5'd12;
                default: ra = 5'($urandom);
            endcase
            drive(($urandom_range(0, 3) == 0), ra, $urandom,
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) == 0), $urandom,
                  ($urandom_range(0, 3) == 0) ? 6'($urandom) : hwint);
            step();
            chk_model($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
